// File: rtl/multi_alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_pkg
// Purpose  : Shared definitions for the multi-channel alarm clock:
//            - alarm channel state encoding
//            - time-of-day limits, plus their BCD digit forms
//            - width of the shared per-channel countdown/ring timer
//            - BCD hh:mm validity check used by time and alarm loads
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_alarm_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RINGING = 2'd1,
    CH_SNOOZED = 2'd2
  } chan_state_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // One 12-bit counter per channel covers both timeouts (up to 3599 s).
  localparam int TIMER_W = 12;

  // Digit-level forms of the limits. These are elaboration-time constants,
  // so the hardware only ever compares digits.
  localparam logic [5:0] SEC_LAST   = 6'(SEC_MAX);
  localparam logic [3:0] DIGIT_LAST = 4'd9;
  localparam logic [3:0] MIN1_LAST  = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN0_LAST  = 4'(MIN_MAX % 10);
  localparam logic [1:0] HOUR1_LAST = 2'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR0_LAST = 4'(HOUR_MAX % 10);

  // True when h1h0:m1m0 is a legal 24-hour BCD time (00:00 .. 23:59).
  function automatic logic bcd_time_valid(
    input logic [1:0] h1,
    input logic [3:0] h0,
    input logic [3:0] m1,
    input logic [3:0] m0
  );
    logic hour_ok;
    hour_ok = (h0 <= DIGIT_LAST) &&
              ((h1 < HOUR1_LAST) || ((h1 == HOUR1_LAST) && (h0 <= HOUR0_LAST)));
    return hour_ok && (m1 <= MIN1_LAST) && (m0 <= DIGIT_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_channel.sv
`default_nettype none
// ============================================================================
// Module   : alarm_channel
// Purpose  : One alarm channel: stored hh:mm and enable, IDLE/RINGING/SNOOZED
//            state machine, and one timer shared between the ring timeout
//            (counts up) and the snooze countdown (counts down).
// Ports    : clock_1s, reset         - 1 Hz clock, async active-high reset
//            time_h1..time_m0        - registered current time (BCD)
//            sec_zero                - current seconds register equals 0
//            load_time               - raw time-load request (blocks trigger)
//            stop_alarm, snooze      - global ring controls
//            write, wr_*             - validated write into this channel
//            ring                    - registered ringing flag
//            ring_next               - ringing flag as of the coming edge
// Revision : 1.0 - initial release
// ============================================================================
module alarm_channel
  import multi_alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       clock_1s,
  input  logic       reset,
  input  logic [1:0] time_h1,
  input  logic [3:0] time_h0,
  input  logic [3:0] time_m1,
  input  logic [3:0] time_m0,
  input  logic       sec_zero,
  input  logic       load_time,
  input  logic       stop_alarm,
  input  logic       snooze,
  input  logic       write,
  input  logic [1:0] wr_h1,
  input  logic [3:0] wr_h0,
  input  logic [3:0] wr_m1,
  input  logic [3:0] wr_m0,
  input  logic       wr_en,
  output logic       ring,
  output logic       ring_next
);

  localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_SEC - 1);
  localparam logic [TIMER_W-1:0] RING_LAST   = TIMER_W'(RING_TIMEOUT_SEC - 1);

  chan_state_t        state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;

  logic [1:0] alarm_h1;
  logic [3:0] alarm_h0;
  logic [3:0] alarm_m1;
  logic [3:0] alarm_m0;
  logic       enabled;
  logic       match;

  // The only cycle with seconds == 0 in a minute is the trigger point, so
  // the alarm fires once per matching minute. A time load on the same edge
  // suppresses the trigger.
  assign match = enabled && sec_zero && !load_time &&
                 (time_h1 == alarm_h1) && (time_h0 == alarm_h0) &&
                 (time_m1 == alarm_m1) && (time_m0 == alarm_m0);

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      state    <= CH_IDLE;
      timer    <= '0;
      alarm_h1 <= '0;
      alarm_h0 <= '0;
      alarm_m1 <= '0;
      alarm_m0 <= '0;
      enabled  <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      // The stored setting updates even when stop_alarm overrides the state.
      if (write) begin
        alarm_h1 <= wr_h1;
        alarm_h0 <= wr_h0;
        alarm_m1 <= wr_m1;
        alarm_m0 <= wr_m0;
        enabled  <= wr_en;
      end
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    if (stop_alarm || write) begin
      state_next = CH_IDLE;
      timer_next = '0;
    end else begin
      case (state)
        CH_IDLE: begin
          if (match) begin
            state_next = CH_RINGING;
            timer_next = '0;
          end
        end
        CH_RINGING: begin
          if (snooze) begin
            state_next = CH_SNOOZED;
            timer_next = SNOOZE_LOAD;
          end else if (match) begin
            // A fresh match (after a time reload) restarts the ring period.
            timer_next = '0;
          end else if (timer == RING_LAST) begin
            state_next = CH_IDLE;
            timer_next = '0;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        CH_SNOOZED: begin
          if (match || (timer == '0)) begin
            state_next = CH_RINGING;
            timer_next = '0;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
        default: begin
          state_next = CH_IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  assign ring      = (state == CH_RINGING);
  assign ring_next = (state_next == CH_RINGING);

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_clock
// Purpose  : 24-hour BCD time-of-day counter advanced by a 1 Hz clock, with
//            NUM_ALARMS independently programmable alarm channels.
// Ports    : clock_1s, reset          - 1 Hz clock, async active-high reset
//            hour_in1..minute_in0     - BCD load value for time or alarm
//            load_time                - load time, seconds := 0
//            load_alarm, alarm_sel,
//            alarm_en_in              - write alarm hh:mm/enable to a channel
//            stop_alarm, snooze       - global ring controls
//            hour_out1..minute_out0   - current time, BCD
//            seconds                  - current seconds, binary 0..59
//            alarm_ring               - per-channel ringing flags
//            alarm                    - OR of all ringing flags
// Revision : 1.0 - initial release
// ============================================================================
module multi_alarm_clock
  import multi_alarm_pkg::*;
#(
  parameter  int NUM_ALARMS       = 4,
  parameter  int SNOOZE_SEC       = 300,
  parameter  int RING_TIMEOUT_SEC = 60,
  localparam int SEL_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clock_1s,
  input  logic                  reset,
  input  logic [1:0]            hour_in1,
  input  logic [3:0]            hour_in0,
  input  logic [3:0]            minute_in1,
  input  logic [3:0]            minute_in0,
  input  logic                  load_time,
  input  logic                  load_alarm,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  alarm_en_in,
  input  logic                  stop_alarm,
  input  logic                  snooze,
  output logic [1:0]            hour_out1,
  output logic [3:0]            hour_out0,
  output logic [3:0]            minute_out1,
  output logic [3:0]            minute_out0,
  output logic [5:0]            seconds,
  output logic [NUM_ALARMS-1:0] alarm_ring,
  output logic                  alarm
);

  logic                  in_valid;
  logic                  time_load_ok;
  logic                  alarm_load_ok;
  logic                  sec_zero;
  logic [NUM_ALARMS-1:0] ring_next;

  assign in_valid      = bcd_time_valid(hour_in1, hour_in0, minute_in1, minute_in0);
  assign time_load_ok  = load_time && in_valid;
  assign alarm_load_ok = load_alarm && in_valid;
  assign sec_zero      = (seconds == '0);

  // Time of day: a valid load wins over the tick; an invalid load is
  // ignored and the clock keeps running.
  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      hour_out1   <= '0;
      hour_out0   <= '0;
      minute_out1 <= '0;
      minute_out0 <= '0;
      seconds     <= '0;
    end else if (time_load_ok) begin
      hour_out1   <= hour_in1;
      hour_out0   <= hour_in0;
      minute_out1 <= minute_in1;
      minute_out0 <= minute_in0;
      seconds     <= '0;
    end else if (seconds == SEC_LAST) begin
      seconds <= '0;
      if ((minute_out1 == MIN1_LAST) && (minute_out0 == MIN0_LAST)) begin
        minute_out1 <= '0;
        minute_out0 <= '0;
        if ((hour_out1 == HOUR1_LAST) && (hour_out0 == HOUR0_LAST)) begin
          hour_out1 <= '0;
          hour_out0 <= '0;
        end else if (hour_out0 == DIGIT_LAST) begin
          hour_out1 <= hour_out1 + 2'd1;
          hour_out0 <= '0;
        end else begin
          hour_out0 <= hour_out0 + 4'd1;
        end
      end else if (minute_out0 == DIGIT_LAST) begin
        minute_out1 <= minute_out1 + 4'd1;
        minute_out0 <= '0;
      end else begin
        minute_out0 <= minute_out0 + 4'd1;
      end
    end else begin
      seconds <= seconds + 6'd1;
    end
  end

  generate
    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_channel
      logic write;
      // Selects beyond NUM_ALARMS-1 match no channel and are dropped.
      assign write = alarm_load_ok && (alarm_sel == SEL_W'(i));

      alarm_channel #(
        .SNOOZE_SEC       (SNOOZE_SEC),
        .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC)
      ) u_channel (
        .clock_1s   (clock_1s),
        .reset      (reset),
        .time_h1    (hour_out1),
        .time_h0    (hour_out0),
        .time_m1    (minute_out1),
        .time_m0    (minute_out0),
        .sec_zero   (sec_zero),
        .load_time  (load_time),
        .stop_alarm (stop_alarm),
        .snooze     (snooze),
        .write      (write),
        .wr_h1      (hour_in1),
        .wr_h0      (hour_in0),
        .wr_m1      (minute_in1),
        .wr_m0      (minute_in0),
        .wr_en      (alarm_en_in),
        .ring       (alarm_ring[i]),
        .ring_next  (ring_next[i])
      );
    end
  endgenerate

  // Registered from the channels' next-state view so it tracks alarm_ring
  // exactly while coming straight from a flop.
  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
    end else begin
      alarm <= |ring_next;
    end
  end

endmodule
`default_nettype wire
